// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access size codes, FSM states,
// alignment checks.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzRsvd = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLd      = 3'd1,
    StStWr    = 3'd2,
    StRmwRd   = 3'd3,
    StRmwWr   = 3'd4,
    StResp    = 3'd5,
    StErrResp = 3'd6
  } state_e;

  function automatic logic is_misaligned(size_e size, logic [1:0] offset);
    logic mis;
    case (size)
      SzByte:  mis = 1'b0;
      SzHalf:  mis = offset[0];
      SzWord:  mis = (offset != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Clears the low address bits a given size cannot use.
  function automatic logic [31:0] align_addr(size_e size, logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    case (size)
      SzByte:  a = addr;
      SzHalf:  a[0] = 1'b0;
      default: a[1:0] = 2'b00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response handshake plus the async_mem word port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extract and extend a load lane, or merge store data into a word.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter bit BigEndian = 1'b1
) (
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_lane = BigEndian ? (2'd3 - offset) : offset;
  assign half_lane = BigEndian ? ~offset[1] : offset[1];
  assign ld_byte   = load_word[{byte_lane, 3'b000} +: 8];
  assign ld_half   = load_word[{half_lane, 4'b0000} +: 16];

  always_comb begin
    load_data  = load_word;
    merge_data = wdata;
    case (size)
      SzByte: begin
        load_data  = {{24{sign_ext & ld_byte[7]}}, ld_byte};
        merge_data = merge_word;
        merge_data[{byte_lane, 3'b000} +: 8] = wdata[7:0];
      end
      SzHalf: begin
        load_data  = {{16{sign_ext & ld_half[15]}}, ld_half};
        merge_data = merge_word;
        merge_data[{half_lane, 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word accesses on async_mem,
// using read-modify-write for sub-word stores. One request outstanding at a time.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit BigEndian     = 1'b1,
  parameter bit ErrOnMisalign = 1'b1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  state_e      state_q, state_d;
  size_e       size_q;
  logic        signed_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;

  size_e       req_size, size_eff;
  logic        accept, misaligned;
  logic [31:0] load_data, merge_data;

  assign req_size   = size_e'(bus.req_size);
  // With error reporting disabled the reserved size behaves as a word access.
  assign size_eff   = (req_size == SzRsvd) ? SzWord : req_size;
  assign misaligned = is_misaligned(req_size, bus.req_addr[1:0]);
  assign accept     = bus.req_valid && (state_q == StIdle);

  lsu_lane_align #(
    .BigEndian(BigEndian)
  ) u_lane_align (
    .size      (size_q),
    .sign_ext  (signed_q),
    .offset    (addr_q[1:0]),
    .load_word (bus.mem_read_data),
    .merge_word(merge_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (misaligned && ErrOnMisalign)  state_d = StErrResp;
          else if (!bus.req_write)          state_d = StLd;
          else if (size_eff == SzWord)      state_d = StStWr;
          else                              state_d = StRmwRd;
        end
      end
      StLd, StStWr, StRmwWr:     state_d = StResp;
      StRmwRd:                   state_d = StRmwWr;
      StResp, StErrResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default:                   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      size_q   <= SzWord;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q   <= size_eff;
        signed_q <= bus.req_signed;
        addr_q   <= align_addr(size_eff, bus.req_addr);
        wdata_q  <= bus.req_wdata;
        rdata_q  <= '0;
      end
      if (state_q == StLd)    rdata_q <= load_data;
      if (state_q == StRmwRd) merge_q <= bus.mem_read_data;
    end
  end

  always_comb begin
    bus.req_ready      = (state_q == StIdle);
    bus.resp_valid     = (state_q == StResp) || (state_q == StErrResp);
    bus.resp_err       = (state_q == StErrResp);
    bus.resp_rdata     = rdata_q;
    bus.mem_write      = (state_q == StStWr) || (state_q == StRmwWr);
    bus.mem_address    = {addr_q[31:2], 2'b00};
    bus.mem_write_data = '0;
    if (state_q == StStWr)  bus.mem_write_data = wdata_q;
    if (state_q == StRmwWr) bus.mem_write_data = merge_data;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural async_mem (combinational read,
// posedge write).
module tb_load_store_unit;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  load_store_unit_if bus ();

  load_store_unit u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: 256 words, word index = address[9:2].
  logic [31:0] mem [0:255];
  logic        poke_we;
  logic [31:0] poke_addr, poke_data;

  assign bus.mem_read_data = mem[bus.mem_address[9:2]];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;
    else if (poke_we)  mem[poke_addr[9:2]] <= poke_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mem_poke(input logic [31:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_we   = 1'b1;
    @(posedge clk);
    #1 poke_we = 1'b0;
  endtask

  // Issues one request from just after a posedge with resp_ready=1; returns response latency
  // in cycles (0 = none within budget), captured response and mem_write pulse count.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nwr);
    lat = 0; nwr = 0; rd = 'x; er = 1'bx;
    bus.resp_ready = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_write) nwr++;
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: ready=%b valid=%b err=%b, want 1 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err);
    end
    tests++;
    if (bus.resp_rdata !== 32'h0 || bus.mem_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h mem_write=%b, want 0 0", bus.resp_rdata, bus.mem_write);
    end
    tests++;
    if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_mem: addr=%h wdata=%h, want 0 0", bus.mem_address, bus.mem_write_data);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_word();
    int lat, nwr; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, lat, rd, er, nwr);
    tests++;
    if (lat !== 2 || nwr !== 1 || rd !== 32'h0 || er !== 1'b0) begin
      fails++;
      $display("FAIL sw_resp: lat=%0d writes=%0d rdata=%h err=%b, want 2 1 0 0", lat, nwr, rd, er);
    end
    tests++;
    if (mem[8'h40] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL sw_mem: got %h, want deadbeef", mem[8'h40]);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, nwr);
    tests++;
    if (lat !== 2 || nwr !== 0 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL lw: lat=%0d writes=%0d rdata=%h err=%b, want 2 0 deadbeef 0",
               lat, nwr, rd, er);
    end
  endtask

  task automatic test_subword_store();
    int lat, nwr; logic [31:0] rd; logic er;
    mem_poke(32'h100, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_007A, lat, rd, er, nwr);
    tests++;
    if (lat !== 3 || nwr !== 1 || er !== 1'b0) begin
      fails++;
      $display("FAIL sb_resp: lat=%0d writes=%0d err=%b, want 3 1 0", lat, nwr, er);
    end
    tests++;
    if (mem[8'h40] !== 32'h117A_3344) begin
      fails++;
      $display("FAIL sb_mem: got %h, want 117a3344", mem[8'h40]);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF_5566, lat, rd, er, nwr);
    tests++;
    if (lat !== 3 || nwr !== 1 || mem[8'h40] !== 32'h117A_5566) begin
      fails++;
      $display("FAIL sh_mem: lat=%0d writes=%0d mem=%h, want 3 1 117a5566", lat, nwr, mem[8'h40]);
    end
  endtask

  task automatic test_load_ext();
    int lat, nwr; logic [31:0] rd; logic er;
    logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [4]  = '{32'h200, 32'h200, 32'h202, 32'h200};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8001};
    mem_poke(32'h200, 32'h8001_8000);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, er, nwr);
      tests++;
      if (lat !== 2 || rd !== exp[i] || er !== 1'b0 || nwr !== 0) begin
        fails++;
        $display("FAIL load_ext[%0d]: lat=%0d rdata=%h err=%b writes=%0d, want 2 %h 0 0",
                 i, lat, rd, er, nwr, exp[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int lat, nwr; logic [31:0] rd; logic er;
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, rd, er, nwr);
    tests++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin
      fails++;
      $display("FAIL lw_misalign: lat=%0d err=%b rdata=%h writes=%0d, want 1 1 0 0",
               lat, er, rd, nwr);
    end
    issue(1'b1, 2'b11, 1'b0, 32'h100, 32'h1234_5678, lat, rd, er, nwr);
    tests++;
    if (lat !== 1 || er !== 1'b1 || nwr !== 0 || mem[8'h40] !== 32'h117A_5566) begin
      fails++;
      $display("FAIL rsvd_size: lat=%0d err=%b writes=%0d mem=%h, want 1 1 0 117a5566",
               lat, er, nwr, mem[8'h40]);
    end
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h100;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_addr = 32'h200;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h117A_5566 ||
          bus.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: valid=%b rdata=%h ready=%b, want 1 117a5566 0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_hs: ready=%b valid=%b, want 1 0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h8001_8000) begin
      fails++;
      $display("FAIL second_req: valid=%b rdata=%h, want 1 80018000",
               bus.resp_valid, bus.resp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int nwr, nresp;
    nwr = 0; nresp = 0;
    mem_poke(32'h104, 32'hCAFE_F00D);
    bus.resp_ready = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b01;
    bus.req_addr   = 32'h104;
    bus.req_wdata  = 32'h0000_BEEF;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    tests++;
    if (bus.req_ready !== 1'b0 || bus.mem_address !== 32'h104) begin
      fails++;
      $display("FAIL rmw_rd: ready=%b addr=%h, want 0 00000104", bus.req_ready, bus.mem_address);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.mem_address !== 32'h0 || bus.mem_write !== 1'b0 ||
        bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: ready=%b addr=%h wr=%b valid=%b, want 1 0 0 0",
               bus.req_ready, bus.mem_address, bus.mem_write, bus.resp_valid);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.mem_write) nwr++;
      if (bus.resp_valid) nresp++;
    end
    tests++;
    if (nwr !== 0 || nresp !== 0 || mem[8'h41] !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL reset_drop: writes=%0d resps=%0d mem=%h, want 0 0 cafef00d",
               nwr, nresp, mem[8'h41]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    poke_we = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_subword_store();
    test_load_ext();
    test_misalign();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end
endmodule
